// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM register: forwarding, ALU, 32-step shift-add multiply.
// Ports: ID/EX controls+operands in, MEM/WB forward path in, EX/MEM bundle + stall_o out.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        WB_i,
  input  logic [1:0]        M_i,
  input  logic              RegDst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [DATA_W-1:0] data2_i,
  input  logic [DATA_W-1:0] sign_extend_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              memwb_RegWrite_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [1:0]        WB_o,
  output logic [1:0]        M_o,
  output logic [DATA_W-1:0] ALUResult_o,
  output logic [DATA_W-1:0] writeData_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              stall_o
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] prod_q, prod_d;
  logic [DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0] mplier_q;
  logic [1:0]        mwb_q, mm_q;
  logic [DATA_W-1:0] mwd_q;
  logic [REG_AW-1:0] mrd_q;

  logic [1:0]        wb_q, m_q;
  logic [DATA_W-1:0] res_q, wd_q;
  logic [REG_AW-1:0] rd_q;

  logic [DATA_W-1:0] fwd_a, fwd_b, op_b, alu_res;
  logic [REG_AW-1:0] dest;
  logic [5:0]        funct;
  logic              is_mul;

  assign funct  = sign_extend_i[5:0];
  assign is_mul = (ALUOp_i == 2'b10) && (funct == 6'h18);
  assign dest   = RegDst_i ? rd_i : rt_i;

  // EX/MEM is younger than MEM/WB, so it takes priority; r0 never forwards.
  always_comb begin
    fwd_a = data1_i;
    if (wb_q[1] && rd_q != '0 && rd_q == rs_i)
      fwd_a = res_q;
    else if (memwb_RegWrite_i && memwb_rd_i != '0 && memwb_rd_i == rs_i)
      fwd_a = memwb_data_i;
  end

  always_comb begin
    fwd_b = data2_i;
    if (wb_q[1] && rd_q != '0 && rd_q == rt_i)
      fwd_b = res_q;
    else if (memwb_RegWrite_i && memwb_rd_i != '0 && memwb_rd_i == rt_i)
      fwd_b = memwb_data_i;
  end

  assign op_b = ALUSrc_i ? sign_extend_i : fwd_b;

  // mul yields 0 here; its result comes from the iterative path.
  always_comb begin
    alu_res = '0;
    unique case (ALUOp_i)
      2'b01: alu_res = fwd_a - op_b;
      2'b10: begin
        case (funct)
          6'h20:   alu_res = fwd_a + op_b;
          6'h22:   alu_res = fwd_a - op_b;
          6'h24:   alu_res = fwd_a & op_b;
          6'h25:   alu_res = fwd_a | op_b;
          6'h2A:   alu_res = {{(DATA_W-1){1'b0}},
                              $signed(fwd_a) < $signed(op_b)};
          default: alu_res = '0;
        endcase
      end
      default: alu_res = fwd_a + op_b;
    endcase
  end

  assign prod_d = mplier_q[0] ? prod_q + mcand_q : prod_q;

  // Gated by reset so a held mul decode cannot stall while in reset.
  assign stall_o = !rst_i &&
                   ((state_q == IDLE && is_mul) || state_q == BUSY);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mwb_q    <= '0;
      mm_q     <= '0;
      mwd_q    <= '0;
      mrd_q    <= '0;
      wb_q     <= '0;
      m_q      <= '0;
      res_q    <= '0;
      wd_q     <= '0;
      rd_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (is_mul) begin
            mcand_q  <= fwd_a;
            mplier_q <= op_b;
            prod_q   <= '0;
            mwb_q    <= WB_i;
            mm_q     <= M_i;
            mwd_q    <= fwd_b;
            mrd_q    <= dest;
            cnt_q    <= '0;
            wb_q     <= '0;
            m_q      <= '0;
            state_q  <= BUSY;
          end else begin
            wb_q  <= WB_i;
            m_q   <= M_i;
            res_q <= alu_res;
            wd_q  <= fwd_b;
            rd_q  <= dest;
          end
        end
        BUSY: begin
          prod_q   <= prod_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          wb_q     <= '0;
          m_q      <= '0;
          if (cnt_q == CW'(DATA_W - 1))
            state_q <= DONE;
        end
        DONE: begin
          wb_q    <= mwb_q;
          m_q     <= mm_q;
          res_q   <= prod_q;
          wd_q    <= mwd_q;
          rd_q    <= mrd_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign WB_o        = wb_q;
  assign M_o         = m_q;
  assign ALUResult_o = res_q;
  assign writeData_o = wd_q;
  assign rd_o        = rd_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage.
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_i, m_i, aluop;
  logic        regdst, alusrc;
  logic [31:0] d1, d2, imm;
  logic [4:0]  rs, rt, rd;
  logic        mw_we;
  logic [4:0]  mw_rd;
  logic [31:0] mw_data;
  logic [1:0]  wb_o, m_o;
  logic [31:0] res_o, wd_o;
  logic [4:0]  rd_o;
  logic        stall;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk_i(clk), .rst_i(rst),
    .WB_i(wb_i), .M_i(m_i), .RegDst_i(regdst),
    .ALUOp_i(aluop), .ALUSrc_i(alusrc),
    .data1_i(d1), .data2_i(d2), .sign_extend_i(imm),
    .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .memwb_RegWrite_i(mw_we), .memwb_rd_i(mw_rd),
    .memwb_data_i(mw_data),
    .WB_o(wb_o), .M_o(m_o), .ALUResult_o(res_o),
    .writeData_o(wd_o), .rd_o(rd_o), .stall_o(stall)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [31:0] res;
    logic [31:0] wd;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] w, input logic [1:0] m,
                       input logic rdst, input logic [1:0] op,
                       input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d);
    wb_i = w; m_i = m; regdst = rdst; aluop = op; alusrc = src;
    d1 = a; d2 = b; imm = im; rs = s; rt = t; rd = d;
  endtask

  task automatic issue(input logic [1:0] w, input logic [1:0] m,
                       input logic rdst, input logic [1:0] op,
                       input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im,
                       input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [31:0] er,
                       input logic [31:0] ew);
    exp_t e;
    drive(w, m, rdst, op, src, a, b, im, s, t, d);
    e.wb = w; e.m = m; e.res = er; e.wd = ew;
    e.rd = rdst ? d : t;
    q.push_back(e);
    #1 chk("stall_nonmul", {31'b0, stall}, 32'd0);
    @(posedge clk); #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (wb_o != 2'b00 || m_o != 2'b00)) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got res=%h rd=%0d want none",
                   res_o, rd_o);
        end else begin
          e = q.pop_front();
          chk("wb", {30'b0, wb_o}, {30'b0, e.wb});
          chk("m", {30'b0, m_o}, {30'b0, e.m});
          chk("res", res_o, e.res);
          chk("wdata", wd_o, e.wd);
          chk("rd", {27'b0, rd_o}, {27'b0, e.rd});
        end
      end
    end
  end

  initial begin : main
    int n;
    rst = 1'b0; mw_we = 1'b0; mw_rd = '0; mw_data = '0;
    drive(2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 0, 0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #1;
    chk("rst0_res", res_o, 32'd0);
    chk("rst0_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;

    // add 5+7 -> r3
    issue(2'b10, 2'b00, 1, 2'b10, 0, 5, 7, 32'h20, 1, 2, 3, 12, 7);
    // sub with EX/MEM forward of r3; MEM/WB r3=99 must lose
    mw_we = 1'b1; mw_rd = 5'd3; mw_data = 32'd99;
    issue(2'b10, 2'b00, 1, 2'b10, 0, 0, 2, 32'h22, 3, 2, 4, 10, 2);
    // MEM/WB forward r5=40
    mw_rd = 5'd5; mw_data = 32'd40;
    issue(2'b10, 2'b00, 1, 2'b10, 0, 1, 2, 32'h20, 5, 6, 6, 42, 2);
    // r0 guard on both paths
    mw_rd = 5'd0; mw_data = 32'd55;
    issue(2'b10, 2'b00, 1, 2'b10, 0, 1, 1, 32'h20, 1, 2, 0, 2, 1);
    issue(2'b10, 2'b00, 1, 2'b10, 0, 7, 8, 32'h20, 0, 0, 10, 15, 8);
    mw_we = 1'b0;
    // and / or / unknown funct
    issue(2'b10, 2'b00, 1, 2'b10, 0, 32'hF0F0, 32'hFF00, 32'h24,
          11, 12, 11, 32'hF000, 32'hFF00);
    issue(2'b10, 2'b00, 1, 2'b10, 0, 32'hF0F0, 32'hFF00, 32'h25,
          13, 14, 12, 32'hFFF0, 32'hFF00);
    issue(2'b10, 2'b00, 1, 2'b10, 0, 9, 9, 32'h3F, 15, 16, 13, 0, 9);
    // ALUOp=01 sub wraps; ALUOp=11 adds with immediate
    issue(2'b10, 2'b00, 0, 2'b01, 0, 3, 5, 0, 17, 18, 1,
          32'hFFFFFFFE, 5);
    issue(2'b10, 2'b00, 0, 2'b11, 1, 32'hFFFFFFFF, 6, 1, 19, 20, 1,
          0, 6);
    // slt -1 < 1 and 1 < -1
    issue(2'b10, 2'b00, 1, 2'b10, 0, 32'hFFFFFFFF, 1, 32'h2A,
          21, 22, 8, 1, 1);
    issue(2'b10, 2'b00, 1, 2'b10, 0, 1, 32'hFFFFFFFF, 32'h2A,
          21, 22, 8, 0, 32'hFFFFFFFF);
    // lw, then sw with store data forwarded from lw result
    issue(2'b11, 2'b10, 0, 2'b00, 1, 32'h100, 32'h5555, 32'hFFFFFFFC,
          23, 9, 0, 32'hFC, 32'h5555);
    issue(2'b00, 2'b01, 0, 2'b00, 1, 32'h200, 0, 4, 24, 9, 0,
          32'h204, 32'hFC);

    // mul: A forwarded from MEM/WB, then MEM/WB changes mid-stall
    mw_we = 1'b1; mw_rd = 5'd25; mw_data = 32'hFFFFFFFF;
    drive(2'b10, 2'b00, 1, 2'b10, 0, 0, 3, 32'h18, 25, 26, 7);
    begin
      exp_t e;
      e.wb = 2'b10; e.m = 2'b00; e.res = 32'hFFFFFFFD;
      e.wd = 32'd3; e.rd = 5'd7;
      q.push_back(e);
    end
    #1 chk("mul_stall_start", {31'b0, stall}, 32'd1);
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
      mw_data = 32'h1234;
      if (stall === 1'b1)
        chk("mul_bubble", {28'b0, wb_o, m_o}, 32'd0);
    end
    chk("mul_stall_cycles", n, 33);
    mw_we = 1'b0;
    @(posedge clk); #2;
    drive(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;

    // reset mid-multiply aborts it
    drive(2'b10, 2'b00, 1, 2'b10, 0, 6, 7, 32'h18, 1, 2, 5);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rstmul_stall", {31'b0, stall}, 32'd0);
    chk("rstmul_wb", {30'b0, wb_o}, 32'd0);
    drive(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (40) @(posedge clk);
    #2 chk("rstmul_idle", {31'b0, stall}, 32'd0);

    // result registered, then reset raised mid-cycle
    issue(2'b10, 2'b01, 1, 2'b10, 0, 100, 23, 32'h20, 1, 2, 17, 123, 23);
    drive(2'b00, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_wb", {30'b0, wb_o}, 32'd0);
    chk("rst_m", {30'b0, m_o}, 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_wd", wd_o, 32'd0);
    chk("rst_rd", {27'b0, rd_o}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
